// File: rtl/operand_loader.sv
// operand_loader: captures two 3-bit operands from board switches on
// successive presses of a (possibly bouncing) load button.
//   clk   - single clock, rising edge
//   rst   - synchronous, active-high reset
//   sw    - operand value, sampled only when a press is seen
//   btn   - raw asynchronous load button, active-high
//   a, b  - registered operands for the downstream adder
//   valid - high while state is DONE (a consistent pair is held)
//   state - FSM encoding for LEDs (00 LOAD_A, 01 LOAD_B, 10 DONE)
// Optional macro OPERAND_LOADER_DEBOUNCE_EN: when defined, a DB_CYCLES
// debouncer filters the synchronised button; otherwise the clean level is a
// one-flop copy of the synchroniser output and every bounce is a press.
module operand_loader #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw,
    input  logic       btn,
    output logic [2:0] a,
    output logic [2:0] b,
    output logic       valid,
    output logic [1:0] state
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        DONE   = 2'b10
    } state_e;

    logic   btn_s1_q;
    logic   btn_s2_q;
    logic   btn_clean_q;
    logic   btn_clean_d;
    logic   clean_prev_q;
    logic   press_c;
    state_e state_q;
    logic [2:0] a_q;
    logic [2:0] b_q;
    logic   valid_q;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
        end
    end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Accept a new level only after it has differed for DB_CYCLES cycles
    always_comb begin
        cnt_d       = '0;
        btn_clean_d = btn_clean_q;
        if (btn_s2_q != btn_clean_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                btn_clean_d = btn_s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // DB_CYCLES has no effect in this build; referenced only to keep it used
    logic [CNT_W-1:0] unused_db_c;
    assign unused_db_c = CNT_W'(DB_CYCLES);

    always_comb begin
        btn_clean_d = btn_s2_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_clean_q  <= 1'b0;
            clean_prev_q <= 1'b0;
        end else begin
            btn_clean_q  <= btn_clean_d;
            clean_prev_q <= btn_clean_q;
        end
    end

    // One-cycle pulse on each rising edge of the clean level
    assign press_c = btn_clean_q & ~clean_prev_q;

    // Operand FSM; valid is registered alongside state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_q     <= 3'b000;
            b_q     <= 3'b000;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (press_c) begin
                        a_q     <= sw;
                        state_q <= LOAD_B;
                        valid_q <= 1'b0;
                    end
                end
                LOAD_B: begin
                    if (press_c) begin
                        b_q     <= sw;
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (press_c) begin
                        a_q     <= sw;
                        state_q <= LOAD_B;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    // Illegal encoding: recover to a clean empty state
                    state_q <= LOAD_A;
                    a_q     <= 3'b000;
                    b_q     <= 3'b000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign valid = valid_q;
    assign state = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Testbench for operand_loader: a cycle-level reference model pushes the
// expected outputs after every clock edge; a monitor pops and compares at
// each falling edge. Directed checks cover the key load/reset scenarios.
module tb_operand_loader;

    localparam int unsigned DB = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int unsigned LAT = 2 + DB;
`else
    localparam int unsigned LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [2:0] sw;
    logic [2:0] a;
    logic [2:0] b;
    logic       valid;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       v;
        logic [1:0] st;
    } obs_t;

    obs_t exp_q[$];

    operand_loader #(.DB_CYCLES(DB)) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .btn  (btn),
        .a    (a),
        .b    (b),
        .valid(valid),
        .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: button delayed two samples, level accepted after it
    // has persisted long enough, presses advance an operand "phase".
    bit         m_s1, m_s2, m_clean, m_prev;
    int         m_run;
    int         m_phase;
    logic [2:0] m_a, m_b;

    always @(posedge clk) begin
        bit   pressed;
        obs_t e;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_clean = 0; m_prev = 0; m_run = 0;
            m_phase = 0; m_a = 3'b000; m_b = 3'b000;
        end else begin
            pressed = m_clean && !m_prev;
            if (pressed) begin
                if (m_phase == 1) begin
                    m_b = sw; m_phase = 2;
                end else begin
                    m_a = sw; m_phase = 1;
                end
            end
            m_prev = m_clean;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
            if (m_s2 != m_clean) begin
                m_run++;
                if (m_run >= int'(DB)) begin
                    m_clean = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
`else
            m_clean = m_s2;
`endif
            m_s2 = m_s1;
            m_s1 = btn;
        end
        e = {m_a, m_b, (m_phase == 2), 2'(m_phase)};
        exp_q.push_back(e);
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        obs_t got;
        obs_t e;
        got = {a, b, valid, state};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty actual=%h required=<entry>", got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t actual a=%0d b=%0d v=%0d st=%0d required a=%0d b=%0d v=%0d st=%0d",
                         $time, got.a, got.b, got.v, got.st, e.a, e.b, e.v, e.st);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_hold(input logic [2:0] v, input int hold);
        sw  = v;
        btn = 1'b1;
        step(hold);
        btn = 1'b0;
        step(12);
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        sw  = 3'b000;
        step(2);
        chk("reset_state", int'(state), 0);
        chk("reset_valid", int'(valid), 0);
        rst = 1'b0;
        step(2);

        // First operand: exact load edge
        sw  = 3'b101;
        btn = 1'b1;
        step(LAT);
        chk("a_before_load_edge", int'(a), 0);
        step(1);
        chk("a_at_load_edge", int'(a), 5);
        chk("state_at_load_edge", int'(state), 1);
        step(10 - LAT - 1);
        btn = 1'b0;
        step(12);
        chk("a_held", int'(a), 5);
        chk("b_still_zero", int'(b), 0);
        chk("valid_low_loadb", int'(valid), 0);

        // Second operand
        press_hold(3'b011, 8);
        chk("b_loaded", int'(b), 3);
        chk("a_kept", int'(a), 5);
        chk("state_done", int'(state), 2);
        chk("valid_done", int'(valid), 1);

        // Reload A from DONE
        press_hold(3'b111, 8);
        chk("a_reloaded", int'(a), 7);
        chk("b_kept", int'(b), 3);
        chk("state_back_loadb", int'(state), 1);
        chk("valid_dropped", int'(valid), 0);

        // Short glitches: 2 high, 2 low, 2 high
        sw  = 3'b010;
        btn = 1'b1; step(2);
        btn = 1'b0; step(2);
        btn = 1'b1; step(2);
        btn = 1'b0; step(14);
`ifdef OPERAND_LOADER_DEBOUNCE_EN
        chk("glitch_a", int'(a), 7);
        chk("glitch_b", int'(b), 3);
        chk("glitch_state", int'(state), 1);
`else
        chk("glitch_a", int'(a), 2);
        chk("glitch_b", int'(b), 2);
        chk("glitch_state", int'(state), 1);
`endif

        // Reset coinciding with a press in LOAD_B
        sw  = 3'b110;
        btn = 1'b1;
        step(LAT);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        btn = 1'b0;
        chk("rst_press_state", int'(state), 0);
        chk("rst_press_a", int'(a), 0);
        chk("rst_press_b", int'(b), 0);
        chk("rst_press_valid", int'(valid), 0);
        step(12);

        // Single-cycle pulse, then a three-pulse bounce
        sw  = 3'b010;
        btn = 1'b1; step(1);
        btn = 1'b0; step(2);
        chk("pulse_a_before", int'(a), 0);
        step(1);
`ifdef OPERAND_LOADER_DEBOUNCE_EN
        chk("pulse_ignored_a", int'(a), 0);
`else
        chk("pulse_a_edge3", int'(a), 2);
`endif
        step(8);
        sw = 3'b001;
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1; step(1);
            btn = 1'b0; step(1);
        end
        step(10);
`ifdef OPERAND_LOADER_DEBOUNCE_EN
        chk("bounce_state", int'(state), 0);
`else
        chk("bounce_state", int'(state), 2);
        chk("bounce_valid", int'(valid), 1);
`endif

        // Randomized presses, holds and occasional resets
        for (int i = 0; i < 60; i++) begin
            sw  = 3'($urandom);
            btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) rst = 1'b1;
            step(1);
            rst = 1'b0;
            step($urandom_range(0, 11));
        end

        btn = 1'b0;
        step(20);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
